// File: rtl/snd_mailbox_pkg.sv
// Shared constants and width helpers for the main->sound command mailbox.
package snd_mailbox_pkg;

    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 4;

    // Width needed to hold an occupancy value from 0 to depth inclusive.
    function automatic int cw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w_of(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/snd_mailbox_if.sv
// Bus bundle between the main CPU port decoder, the sound CPU and the mailbox.
interface snd_mailbox_if #(
    parameter int DW = 8,
    parameter int CW = 3
);

    logic          m_wr;
    logic [DW-1:0] m_din;
    logic [CW-1:0] m_count;
    logic          m_full;
    logic          m_ovf;
    logic          m_ovf_clr;
    logic [DW-1:0] m_reply;
    logic          m_reply_valid;
    logic          m_reply_rd;
    logic          s_cen;
    logic          s_rd;
    logic [DW-1:0] s_dout;
    logic          s_empty;
    logic          s_nmi;
    logic          s_ack;
    logic          s_reply_wr;
    logic [DW-1:0] s_reply_din;

    // CPU side: drives strobes and data, observes status.
    modport master (
        output m_wr, m_din, m_ovf_clr, m_reply_rd,
        output s_cen, s_rd, s_ack, s_reply_wr, s_reply_din,
        input  m_count, m_full, m_ovf, m_reply, m_reply_valid,
        input  s_dout, s_empty, s_nmi
    );

    // Mailbox side.
    modport slave (
        input  m_wr, m_din, m_ovf_clr, m_reply_rd,
        input  s_cen, s_rd, s_ack, s_reply_wr, s_reply_din,
        output m_count, m_full, m_ovf, m_reply, m_reply_valid,
        output s_dout, s_empty, s_nmi
    );

endinterface

// File: rtl/snd_mailbox_fifo.sv
// Command FIFO: pointers, occupancy, storage and the full-write overwrite rule.
module mbox_fifo
    import snd_mailbox_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int OVERWRITE = 0,
    parameter int CW        = cw_of(DEPTH)
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          wr,
    input  logic [DW-1:0] din,
    input  logic          rd,
    output logic [DW-1:0] dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ovf_evt,
    output logic          pop_evt,
    output logic          ow_evt
);

    localparam int PW = ptr_w_of(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr_prev;
    logic          push_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign pop_evt   = rd && !empty;
    // A pop on the same edge makes room, so a push into a full FIFO is not an overflow then.
    assign push_ok   = wr && (!full || pop_evt);
    assign ovf_evt   = wr && full && !pop_evt;
    assign ow_evt    = ovf_evt && (OVERWRITE != 0);
    assign wptr_prev = (wptr == '0) ? LAST : wptr - 1'b1;
    assign dout      = empty ? '0 : mem[rptr];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= next_ptr(wptr);
            if (pop_evt) rptr <= next_ptr(rptr);
            case ({push_ok, pop_evt})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; stale contents are masked by the empty check on dout.
    always_ff @(posedge clk_sys) begin
        if (push_ok)
            mem[wptr] <= din;
        else if (ow_evt)
            mem[wptr_prev] <= din;
    end

endmodule

// File: rtl/snd_mailbox.sv
// Main->sound command mailbox: FIFO, sticky overflow, NMI arming and reply register.
module snd_mailbox
    import snd_mailbox_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int OVERWRITE = 0,
    parameter int CW        = cw_of(DEPTH)
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    snd_mailbox_if.slave bus
);

    logic [DW-1:0] fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          ovf_evt;
    logic          pop_evt;
    logic          ow_evt;
    logic          armed;
    logic          nmi_set;
    logic          m_ovf_q;
    logic          s_nmi_q;
    logic [DW-1:0] reply_q;
    logic          reply_valid_q;

    mbox_fifo #(
        .DW        (DW),
        .DEPTH     (DEPTH),
        .OVERWRITE (OVERWRITE),
        .CW        (CW)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .wr      (bus.m_wr),
        .din     (bus.m_din),
        .rd      (bus.s_rd),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .ovf_evt (ovf_evt),
        .pop_evt (pop_evt),
        .ow_evt  (ow_evt)
    );

    assign nmi_set = bus.s_cen && !s_nmi_q && armed && (fifo_count != '0);

    // A set consumes the arm even when an ack on the same edge suppresses the NMI itself,
    // so a software ack without a read cannot cause repeated NMIs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            armed         <= 1'b1;
            s_nmi_q       <= 1'b0;
            m_ovf_q       <= 1'b0;
            reply_q       <= '0;
            reply_valid_q <= 1'b0;
        end else begin
            if (nmi_set)
                armed <= 1'b0;
            if (pop_evt || ow_evt)
                armed <= 1'b1;

            if (bus.s_ack)
                s_nmi_q <= 1'b0;
            else if (nmi_set)
                s_nmi_q <= 1'b1;

            if (ovf_evt)
                m_ovf_q <= 1'b1;
            else if (bus.m_ovf_clr)
                m_ovf_q <= 1'b0;

            if (bus.s_reply_wr) begin
                reply_q       <= bus.s_reply_din;
                reply_valid_q <= 1'b1;
            end else if (bus.m_reply_rd) begin
                reply_valid_q <= 1'b0;
            end
        end
    end

    assign bus.m_count       = fifo_count;
    assign bus.m_full        = fifo_full;
    assign bus.m_ovf         = m_ovf_q;
    assign bus.m_reply       = reply_q;
    assign bus.m_reply_valid = reply_valid_q;
    assign bus.s_dout        = fifo_dout;
    assign bus.s_empty       = fifo_empty;
    assign bus.s_nmi         = s_nmi_q;

endmodule
